// File: rtl/ucie_tx_fifo_writer_if.sv
// Stream-in / FIFO-write-port bundle for the TX FIFO packer.
// The slave modport is the packer; the master side is the upstream source plus the FIFO full flag.
interface ucie_tx_fifo_writer_if #(
    parameter int IN_WIDTH = 32,
    parameter int PACK     = 4
);
    localparam int WW = $clog2(PACK);

    logic                     in_valid;
    logic [IN_WIDTH-1:0]      in_data;
    logic                     in_last;
    logic                     in_ready;
    logic                     wfull;
    logic                     winc;
    logic [IN_WIDTH*PACK-1:0] wdata;
    logic [WW-1:0]            wwords;
    logic                     wlast;

    modport master (
        output in_valid, in_data, in_last, wfull,
        input  in_ready, winc, wdata, wwords, wlast
    );

    modport slave (
        input  in_valid, in_data, in_last, wfull,
        output in_ready, winc, wdata, wwords, wlast
    );
endinterface

// File: rtl/ucie_tx_fifo_writer.sv
// Write-side packer for the TX async FIFO: gathers up to PACK stream words per entry
// and writes each entry with a single winc pulse gated by wfull.
module ucie_tx_fifo_writer #(
    parameter int IN_WIDTH  = 32,
    parameter int PACK      = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 w_clk,
    input  logic                 wrst,
    ucie_tx_fifo_writer_if.slave bus,
    output logic [CNT_WIDTH-1:0] pkt_cnt
);
    localparam int ENT_W = IN_WIDTH * PACK;
    localparam int IDX_W = $clog2(PACK);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PACK - 1);

    // Encoding is {acc_done, stg_valid}; 2'b10 is never entered.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        STAGED  = 2'b01,
        BLOCKED = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic             acc_done, stg_valid;
    logic [ENT_W-1:0] acc_data, acc_base, acc_merged, stg_data;
    logic [IDX_W-1:0] idx, wr_idx, stg_words;
    logic             acc_last, stg_last;
    logic             drain, stage_free, acc_move, handshake, entry_done;
    logic             mv_acc, ld_in;

    assign acc_done  = (state == BLOCKED);
    assign stg_valid = (state != IDLE);

    // Reset also masks drain so no entry is written in the reset cycle.
    assign drain      = stg_valid & ~bus.wfull & ~wrst;
    assign stage_free = ~stg_valid | drain;
    assign acc_move   = acc_done & stage_free;

    assign bus.in_ready = ~wrst & (~acc_done | stage_free);
    assign handshake    = bus.in_valid & bus.in_ready;

    // A word accepted alongside a held-entry move lands in slot 0 of the cleared accumulator.
    assign wr_idx     = acc_move ? '0 : idx;
    assign acc_base   = acc_move ? '0 : acc_data;
    assign entry_done = handshake & ((wr_idx == IDX_MAX) | bus.in_last);

    always_comb begin
        acc_merged = acc_base;
        for (int i = 0; i < PACK; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                acc_merged[i*IN_WIDTH +: IN_WIDTH] = bus.in_data;
            end
        end
    end

    assign bus.winc   = drain;
    assign bus.wdata  = stg_data;
    assign bus.wwords = stg_words;
    assign bus.wlast  = stg_last;

    always_ff @(posedge w_clk) begin
        if (wrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mv_acc    = 1'b0;
        ld_in     = 1'b0;
        case (state)
            IDLE: begin
                if (entry_done) begin
                    ld_in     = 1'b1;
                    state_nxt = STAGED;
                end
            end
            STAGED: begin
                if (entry_done) begin
                    if (drain) begin
                        ld_in = 1'b1;
                    end else begin
                        state_nxt = BLOCKED;
                    end
                end else if (drain) begin
                    state_nxt = IDLE;
                end
            end
            BLOCKED: begin
                if (drain) begin
                    mv_acc    = 1'b1;
                    state_nxt = entry_done ? BLOCKED : STAGED;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator and stage registers
    always_ff @(posedge w_clk) begin
        if (wrst) begin
            acc_data  <= '0;
            idx       <= '0;
            acc_last  <= 1'b0;
            stg_data  <= '0;
            stg_words <= '0;
            stg_last  <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            if (bus.winc & stg_last) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end

            if (mv_acc) begin
                stg_data  <= acc_data;
                stg_words <= idx;
                stg_last  <= acc_last;
            end else if (ld_in) begin
                stg_data  <= acc_merged;
                stg_words <= wr_idx;
                stg_last  <= bus.in_last;
            end

            if (ld_in) begin
                acc_data <= '0;
                idx      <= '0;
                acc_last <= 1'b0;
            end else if (handshake) begin
                acc_data <= acc_merged;
                acc_last <= bus.in_last;
                idx      <= entry_done ? wr_idx : wr_idx + 1'b1;
            end else if (mv_acc) begin
                acc_data <= '0;
                idx      <= '0;
                acc_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ucie_tx_fifo_writer.sv
// Directed bench for ucie_tx_fifo_writer: expected FIFO entries are queued as stimulus is issued
// and a negedge monitor pops and compares them on every winc.
`timescale 1ns/1ps
module tb_ucie_tx_fifo_writer;
    localparam int IN_WIDTH  = 32;
    localparam int PACK      = 4;
    localparam int CNT_WIDTH = 4;

    typedef struct packed {
        logic [127:0] d;
        logic [1:0]   w;
        logic         l;
    } ent_t;

    logic                 w_clk = 1'b0;
    logic                 wrst;
    logic [CNT_WIDTH-1:0] pkt_cnt;

    ucie_tx_fifo_writer_if #(.IN_WIDTH(IN_WIDTH), .PACK(PACK)) bus ();

    ucie_tx_fifo_writer #(
        .IN_WIDTH (IN_WIDTH),
        .PACK     (PACK),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .w_clk  (w_clk),
        .wrst   (wrst),
        .bus    (bus),
        .pkt_cnt(pkt_cnt)
    );

    always #5 w_clk = ~w_clk;

    ent_t                 expq[$];
    ent_t                 mon_e;
    int                   checks   = 0;
    int                   errors   = 0;
    int                   accepted = 0;
    int                   wf_mode  = 0;
    logic [CNT_WIDTH-1:0] exp_cnt  = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [127:0] d, input logic [1:0] w, input logic l);
        ent_t e;
        e.d = d;
        e.w = w;
        e.l = l;
        expq.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic l);
        int   n;
        logic hs;
        n  = 0;
        hs = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!hs && n < 200) begin
            @(negedge w_clk);
            hs = bus.in_ready;
            @(posedge w_clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        if (hs) begin
            accepted++;
        end else begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %0h got no in_ready in 200 cycles, expected acceptance", d);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(posedge w_clk);
            #1;
            n++;
        end
        @(posedge w_clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d entries outstanding, expected 0", name, expq.size());
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_winc"},     bus.winc,     '0);
        chk({name, "_wdata"},    bus.wdata,    '0);
        chk({name, "_wwords"},   bus.wwords,   '0);
        chk({name, "_wlast"},    bus.wlast,    '0);
        chk({name, "_pkt_cnt"},  pkt_cnt,      '0);
        chk({name, "_in_ready"}, bus.in_ready, '0);
    endtask

    // Sole driver of wfull: 0 = low, 1 = high, 2 = toggle every cycle.
    initial begin
        bus.wfull = 1'b0;
        forever begin
            @(posedge w_clk);
            #1;
            case (wf_mode)
                1:       bus.wfull = 1'b1;
                2:       bus.wfull = ~bus.wfull;
                default: bus.wfull = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor
    always @(negedge w_clk) begin
        if (wrst === 1'b0) begin
            chk("pkt_cnt_track", pkt_cnt, exp_cnt);
            if (bus.winc === 1'b1) begin
                chk("winc_while_full", bus.wfull, '0);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_winc: got wdata %0h, expected no write", bus.wdata);
                end else begin
                    mon_e = expq.pop_front();
                    chk("wdata",  bus.wdata,  mon_e.d);
                    chk("wwords", bus.wwords, mon_e.w);
                    chk("wlast",  bus.wlast,  mon_e.l);
                    if (mon_e.l) exp_cnt = exp_cnt + 1'b1;
                end
            end
        end else if (wrst === 1'b1) begin
            exp_cnt = '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200us, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        wrst         = 1'b1;
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        chk_reset_outputs("reset");
        @(posedge w_clk);
        #1;
        wrst = 1'b0;

        // Four words packed into one entry
        push_exp(128'h00000044_00000033_00000022_00000011, 2'd3, 1'b1);
        send_word(32'h11, 1'b0);
        send_word(32'h22, 1'b0);
        send_word(32'h33, 1'b0);
        send_word(32'h44, 1'b1);
        @(negedge w_clk);
        chk("pack_latency_winc", bus.winc, 1'b1);
        wait_drain("pack");
        chk("pack_pkt_cnt", pkt_cnt, 4'd1);

        // Single-word packet
        push_exp(128'h000000AA, 2'd0, 1'b1);
        send_word(32'hAA, 1'b1);
        wait_drain("short");
        chk("short_pkt_cnt", pkt_cnt, 4'd2);

        // Back-pressure: wfull held while twelve words stream in
        wf_mode = 1;
        repeat (2) begin
            @(posedge w_clk);
            #1;
        end
        push_exp(128'h00000004_00000003_00000002_00000001, 2'd3, 1'b0);
        push_exp(128'h00000008_00000007_00000006_00000005, 2'd3, 1'b0);
        push_exp(128'h0000000C_0000000B_0000000A_00000009, 2'd3, 1'b1);
        accepted = 0;
        fork
            begin
                for (int i = 1; i <= 12; i++) send_word(32'(i), (i == 12));
            end
            begin
                repeat (10) @(posedge w_clk);
                @(negedge w_clk);
                chk("bp_winc_low", bus.winc, 1'b0);
                chk("bp_wdata_stable", bus.wdata, 128'h00000004_00000003_00000002_00000001);
                chk("bp_accepted", 128'(accepted), 128'd8);
                chk("bp_in_ready_low", bus.in_ready, 1'b0);
                @(posedge w_clk);
                #1;
                wf_mode = 0;
            end
        join
        wait_drain("backpressure");
        chk("bp_pkt_cnt", pkt_cnt, 4'd3);

        // wfull toggling against continuous input
        wf_mode = 2;
        push_exp(128'h00000024_00000023_00000022_00000021, 2'd3, 1'b0);
        push_exp(128'h00000025, 2'd0, 1'b1);
        push_exp(128'h00000032_00000031, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++) send_word(32'h21 + 32'(i), (i == 4));
        send_word(32'h31, 1'b0);
        send_word(32'h32, 1'b1);
        wait_drain("race");
        wf_mode = 0;
        repeat (2) begin
            @(posedge w_clk);
            #1;
        end
        chk("race_pkt_cnt", pkt_cnt, 4'd5);

        // Reset in the middle of a packet
        send_word(32'h51, 1'b0);
        send_word(32'h52, 1'b0);
        wrst = 1'b1;
        @(posedge w_clk);
        @(negedge w_clk);
        chk_reset_outputs("midreset");
        @(posedge w_clk);
        #1;
        wrst = 1'b0;
        push_exp(128'h00000064_00000063_00000062_00000061, 2'd3, 1'b1);
        for (int i = 0; i < 4; i++) send_word(32'h61 + 32'(i), (i == 3));
        wait_drain("midreset");
        chk("midreset_pkt_cnt", pkt_cnt, 4'd1);

        // Counter wrap with 17 single-word packets
        wrst = 1'b1;
        repeat (2) @(posedge w_clk);
        #1;
        wrst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push_exp(128'h80 + 128'(i), 2'd0, 1'b1);
            send_word(32'h80 + 32'(i), 1'b1);
        end
        wait_drain("wrap");
        chk("wrap_pkt_cnt", pkt_cnt, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
